logic_proc_sequencer: RTL and testbench

//  Initiator for the 4-bit logic processor's front-panel interface. It turns one

---
 rtl/logic_proc_pkg.sv | 47 ++++
 rtl/logic_proc_sequencer_if.sv | 26 ++
 rtl/logic_proc_sequencer_seq_delay_cnt.sv | 26 ++
 rtl/logic_proc_sequencer.sv | 152 +++++++++++++++
 tb/tb_logic_proc_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_proc_pkg.sv
// Shared types and constants for the logic-processor front-panel sequencer.
package logic_proc_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        READ   = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    // Processor function select (F) codes
    localparam logic [2:0] F_AND   = 3'b000;
    localparam logic [2:0] F_OR    = 3'b001;
    localparam logic [2:0] F_XOR   = 3'b010;
    localparam logic [2:0] F_ONES  = 3'b011;
    localparam logic [2:0] F_NAND  = 3'b100;
    localparam logic [2:0] F_NOR   = 3'b101;
    localparam logic [2:0] F_XNOR  = 3'b110;
    localparam logic [2:0] F_ZEROS = 3'b111;

    // Processor routing select (R) codes
    localparam logic [1:0] R_HOLD = 2'b00;
    localparam logic [1:0] R_TO_B = 2'b01;
    localparam logic [1:0] R_TO_A = 2'b10;
    localparam logic [1:0] R_SWAP = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/logic_proc_sequencer_if.sv
// Command/response handshake bundle between a controller and the sequencer.
interface logic_proc_sequencer_if #(parameter int DATA_W = 4);
    import logic_proc_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_t           cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [2:0]        cmd_f;
    logic [1:0]        cmd_r;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_f, cmd_r, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_f, cmd_r, rsp_ready,
        output cmd_ready, rsp_valid, rsp_a, rsp_b
    );

endinterface

// File: rtl/logic_proc_sequencer_seq_delay_cnt.sv
// Loadable down-counter shared by the SETUP, STROBE and WAIT phases.
// done is high during the last cycle of a loaded interval.
module seq_delay_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    // Load a fresh interval or step towards zero; parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0) || (cnt == CNT_W'(1));

endmodule

// File: rtl/logic_proc_sequencer.sv
// Turns one handshaked command into a timed Din/F/R + active-low strobe
// sequence for the 4-bit logic processor, then returns sampled Aval/Bval.
module logic_proc_sequencer
    import logic_proc_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int EXEC_WAIT = 12
) (
    input  logic                   Clk,
    input  logic                   Reset,
    logic_proc_sequencer_if.slave  bus,
    output logic [DATA_W-1:0]      Din,
    output logic [2:0]             F,
    output logic [1:0]             R,
    output logic                   LoadA,
    output logic                   LoadB,
    output logic                   Execute,
    input  logic [DATA_W-1:0]      Aval,
    input  logic [DATA_W-1:0]      Bval
);
    localparam int CNT_MAX = max3(SETUP_CYC, PULSE_CYC, EXEC_WAIT);
    localparam int CNT_W   = cnt_width(CNT_MAX);

    seq_state_t       state, state_nxt;
    cmd_op_t          op_q, op_nxt;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    // cmd_ready is only ever high while in IDLE, so this is the acceptance edge.
    assign accept = bus.cmd_valid & bus.cmd_ready;

    seq_delay_cnt #(.CNT_W(CNT_W)) u_delay (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Next-state, latched-op and counter-load decisions for the sequence.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    case (bus.cmd_op)
                        LOAD_A, LOAD_B, EXEC: begin
                            op_nxt = bus.cmd_op;
                            if (SETUP_CYC > 0) begin
                                state_nxt = ST_SETUP;
                                cnt_val   = CNT_W'(SETUP_CYC);
                            end else begin
                                state_nxt = ST_STROBE;
                                cnt_val   = CNT_W'(PULSE_CYC);
                            end
                        end
                        default: begin
                            // READ and any unknown encoding: just sample the registers
                            op_nxt    = READ;
                            state_nxt = ST_WAIT;
                            cnt_val   = CNT_W'(1);
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_nxt = ST_STROBE;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(PULSE_CYC);
                end
            end
            ST_STROBE: begin
                if (cnt_done)
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_nxt = ST_WAIT;
                cnt_load  = 1'b1;
                cnt_val   = (op_q == EXEC) ? CNT_W'(EXEC_WAIT) : CNT_W'(1);
            end
            ST_WAIT: begin
                if (cnt_done)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and latched command opcode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            op_q  <= READ;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
        end
    end

    // Registered processor drive, strobes and handshake outputs; strobes are
    // decoded from the next state so each is low exactly while in STROBE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Din           <= '0;
            F             <= '0;
            R             <= '0;
            LoadA         <= 1'b1;
            LoadB         <= 1'b1;
            Execute       <= 1'b1;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_a     <= '0;
            bus.rsp_b     <= '0;
        end else begin
            bus.cmd_ready <= (state_nxt == ST_IDLE);
            if (accept) begin
                case (bus.cmd_op)
                    LOAD_A, LOAD_B: Din <= bus.cmd_data;
                    EXEC: begin
                        F <= bus.cmd_f;
                        R <= bus.cmd_r;
                    end
                    default: ;
                endcase
            end
            LoadA   <= !((state_nxt == ST_STROBE) && (op_nxt == LOAD_A));
            LoadB   <= !((state_nxt == ST_STROBE) && (op_nxt == LOAD_B));
            Execute <= !((state_nxt == ST_STROBE) && (op_nxt == EXEC));
            if ((state == ST_WAIT) && cnt_done) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_a     <= Aval;
                bus.rsp_b     <= Bval;
            end else if ((state == ST_RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_proc_sequencer.sv
// Directed bench for logic_proc_sequencer with a behavioural 4-bit processor.
module tb_logic_proc_sequencer;
    import logic_proc_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] Din;
    logic [2:0] F;
    logic [1:0] R;
    logic       LoadA, LoadB, Execute;
    logic [3:0] Aval, Bval;

    logic_proc_sequencer_if #(.DATA_W(4)) bus();

    logic_proc_sequencer #(
        .DATA_W(4), .SETUP_CYC(1), .PULSE_CYC(2), .EXEC_WAIT(12)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus),
        .Din(Din), .F(F), .R(R),
        .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
        .Aval(Aval), .Bval(Bval)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural processor: loads on low strobes, executes once per Execute fall.
    logic [3:0] ma = 4'h0;
    logic [3:0] mb = 4'h0;
    logic       exec_prev = 1'b1;
    logic [3:0] res;
    assign Aval = ma;
    assign Bval = mb;

    function automatic logic [3:0] alu(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return 4'hF;
            3'b100:  return ~(a & b);
            3'b101:  return ~(a | b);
            3'b110:  return ~(a ^ b);
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (!LoadA) ma <= Din;
        if (!LoadB) mb <= Din;
        if (!Execute && exec_prev) begin
            res = alu(F, ma, mb);
            case (R)
                2'b01:   mb <= res;
                2'b10:   ma <= res;
                2'b11:   begin ma <= mb; mb <= ma; end
                default: ;
            endcase
        end
        exec_prev <= Execute;
    end

    // Strobe monitor: pulse widths, overlap and Din/F/R stability during pulses.
    int cur_a = 0, cur_b = 0, cur_x = 0;
    int len_a = 0, len_b = 0, len_x = 0, pulses_a = 0;
    logic multi_low = 1'b0, din_moved = 1'b0, fr_moved = 1'b0;
    logic [3:0] din_fall;
    logic [4:0] fr_fall;
    always @(negedge Clk) begin
        if (!LoadA) cur_a++; else if (cur_a > 0) begin len_a = cur_a; cur_a = 0; pulses_a++; end
        if (!LoadB) cur_b++; else if (cur_b > 0) begin len_b = cur_b; cur_b = 0; end
        if (!Execute) cur_x++; else if (cur_x > 0) begin len_x = cur_x; cur_x = 0; end
        if ((int'(!LoadA) + int'(!LoadB) + int'(!Execute)) > 1) multi_low = 1'b1;
        if ((!LoadA && cur_a == 1) || (!LoadB && cur_b == 1)) din_fall = Din;
        else if ((!LoadA || !LoadB) && Din !== din_fall) din_moved = 1'b1;
        if (!Execute && cur_x == 1) fr_fall = {F, R};
        else if (!Execute && {F, R} !== fr_fall) fr_moved = 1'b1;
    end

    // One full command: accept, latency, response values, optional backpressure.
    task automatic run_cmd(input string tag, input cmd_op_t op, input logic [3:0] data,
                           input logic [2:0] f, input logic [1:0] r, input int hold,
                           input int exp_lat, input logic [3:0] exp_a, input logic [3:0] exp_b);
        int w;
        int lat;
        w = 0;
        @(negedge Clk);
        while (!bus.cmd_ready && w < 50) begin @(negedge Clk); w++; end
        check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_f     = f;
        bus.cmd_r     = r;
        @(negedge Clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~data;
        bus.cmd_f     = ~f;
        bus.cmd_r     = ~r;
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin @(negedge Clk); lat++; end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rsp_a"}, 32'(bus.rsp_a), 32'(exp_a));
        check({tag, ".rsp_b"}, 32'(bus.rsp_b), 32'(exp_b));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = LOAD_A;
                bus.cmd_data  = 4'hF;
            end
            @(negedge Clk);
            check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(bus.cmd_ready), 32'd0);
            check({tag, ".hold_rsp"}, 32'({bus.rsp_a, bus.rsp_b}), 32'({exp_a, exp_b}));
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge Clk);
        bus.rsp_ready = 1'b0;
        check({tag, ".rsp_cleared"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        logic seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = READ;
        bus.cmd_data  = 4'h0;
        bus.cmd_f     = 3'h0;
        bus.cmd_r     = 2'h0;
        bus.rsp_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst.strobes", 32'({LoadA, LoadB, Execute}), 32'h7);
        check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.din_f_r", 32'({Din, F, R}), 32'd0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("post_rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst.strobes", 32'({LoadA, LoadB, Execute}), 32'h7);

        // Register loads
        run_cmd("load_a", LOAD_A, 4'hB, 3'h0, 2'h0, 0, 5, 4'hB, 4'h0);
        check("load_a.pulse_len", 32'(len_a), 32'd2);
        run_cmd("load_b", LOAD_B, 4'h2, 3'h0, 2'h0, 0, 5, 4'hB, 4'h2);
        check("load_b.pulse_len", 32'(len_b), 32'd2);

        // Executes
        run_cmd("exec_xor", EXEC, 4'h0, F_XOR, R_TO_A, 0, 16, 4'h9, 4'h2);
        run_cmd("exec_xnor", EXEC, 4'h0, F_XNOR, R_TO_B, 0, 16, 4'h9, 4'h4);
        run_cmd("exec_swap", EXEC, 4'h0, F_AND, R_SWAP, 0, 16, 4'h4, 4'h9);
        check("exec_swap.pulse_len", 32'(len_x), 32'd2);
        check("exec_swap.f_r_kept", 32'({F, R}), 32'({F_AND, R_SWAP}));

        // Response backpressure with a pending command
        run_cmd("read_bp", READ, 4'h0, 3'h0, 2'h0, 5, 1, 4'h4, 4'h9);
        check("read_bp.no_accept_pulses", 32'(pulses_a), 32'd1);
        check("read_bp.din_kept", 32'(Din), 32'h2);

        // Reset during the Execute pulse
        @(negedge Clk);
        w = 0;
        while (!bus.cmd_ready && w < 50) begin @(negedge Clk); w++; end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = EXEC;
        bus.cmd_f     = F_ZEROS;
        bus.cmd_r     = R_HOLD;
        @(negedge Clk);
        bus.cmd_valid = 1'b0;
        w = 0;
        while (Execute && w < 20) begin @(negedge Clk); w++; end
        check("rst_mid.exec_low", 32'(Execute), 32'd0);
        #2 Reset = 1'b0;
        #1;
        check("rst_mid.exec_high", 32'(Execute), 32'd1);
        check("rst_mid.cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("rst_mid.no_rsp", 32'(seen), 32'd0);
        check("rst_mid.f_r_cleared", 32'({F, R}), 32'd0);
        run_cmd("exec_after_rst", EXEC, 4'h0, F_AND, R_TO_A, 0, 16, 4'h0, 4'h9);
        check("exec_after_rst.pulse_len", 32'(len_x), 32'd2);

        // Whole-run strobe properties
        check("strobe_overlap", 32'(multi_low), 32'd0);
        check("din_stable", 32'(din_moved), 32'd0);
        check("f_r_stable", 32'(fr_moved), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
